// File: rtl/nxn_game_core_pkg.sv
// game_pkg: shared types and constants for the N x N game controller.
//   game_state_t : top-level controller states
//   scan_state_t : line scanner sequencer states
//   cell_t       : board cell encoding (00 empty, 01 X, 10 O)
//   ASC_*        : ASCII status characters driven on game_st
//   dir_dr/dir_dc: per-direction row/column step, (0,1) (1,0) (1,1) (1,-1)
package game_pkg;

   typedef enum logic [3:0] {
      ST_START, ST_TURN_X, ST_ERR_X, ST_SCAN, ST_TURN_O,
      ST_ERR_O, ST_WIN_X, ST_WIN_O, ST_DRAW
   } game_state_t;

   typedef enum logic [1:0] {LS_IDLE, LS_STEP, LS_DONE} scan_state_t;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_X     = 2'b01,
      CELL_O     = 2'b10
   } cell_t;

   localparam logic [7:0] ASC_X = 8'h58;
   localparam logic [7:0] ASC_O = 8'h4F;
   localparam logic [7:0] ASC_C = 8'h43;
   localparam logic [7:0] ASC_E = 8'h45;
   localparam logic [7:0] ASC_N = 8'h6E;

   function automatic logic signed [1:0] dir_dr(input logic [1:0] d);
      return (d == 2'd0) ? 2'sd0 : 2'sd1;
   endfunction

   function automatic logic signed [1:0] dir_dc(input logic [1:0] d);
      logic signed [1:0] v;
      case (d)
         2'd0:    v = 2'sd1;
         2'd1:    v = 2'sd0;
         2'd2:    v = 2'sd1;
         default: v = -2'sd1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/nxn_game_core_line_scan.sv
// line_scan: walks the four lines through the last placed cell and reports
// whether any of them holds a run of WIN_LEN cells of the mover's value.
//   clk, reset       : clock, async active-low reset
//   clear            : synchronous abort back to idle
//   start            : one-cycle kick; row/col/player are sampled here
//   q_row, q_col     : neighbour being queried (IW+1 bits, off-board = >= N)
//   q_cell           : board value at the queried cell (00 when off-board)
//   done, win, dir   : one-cycle result strobe, win flag, winning direction
//
// state   | meaning
// LS_IDLE | waiting for start
// LS_STEP | stepping along dir, +delta half then -delta half
// LS_DONE | result valid for one cycle
module line_scan
   import game_pkg::*;
#(
   parameter int N       = 3,
   parameter int WIN_LEN = 3,
   parameter int IW      = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          start,
   input  logic [IW-1:0] row,
   input  logic [IW-1:0] col,
   input  logic [1:0]    player,
   output logic [IW:0]   q_row,
   output logic [IW:0]   q_col,
   input  logic [1:0]    q_cell,
   output logic          done,
   output logic          win,
   output logic [1:0]    dir
);

   localparam logic [3:0] WL = 4'(WIN_LEN);

   scan_state_t st, st_n;
   logic [IW:0] org_r, org_c, pos_r, pos_c, pos_r_n, pos_c_n;
   logic [IW:0] dre, dce;
   logic [1:0]  ply, d, d_n;
   logic        neg, neg_n, win_r, win_n;
   logic [3:0]  cnt, cnt_n;

   // sign-extend the 2-bit delta so that 0 - 1 wraps to a value >= N
   assign dre   = (IW+1)'(dir_dr(d));
   assign dce   = (IW+1)'(dir_dc(d));
   assign q_row = neg ? pos_r - dre : pos_r + dre;
   assign q_col = neg ? pos_c - dce : pos_c + dce;

   assign done = (st == LS_DONE);
   assign win  = win_r;
   assign dir  = d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st    <= LS_IDLE;
         org_r <= '0;
         org_c <= '0;
         pos_r <= '0;
         pos_c <= '0;
         ply   <= '0;
         d     <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
         win_r <= 1'b0;
      end else begin
         st    <= st_n;
         pos_r <= pos_r_n;
         pos_c <= pos_c_n;
         d     <= d_n;
         neg   <= neg_n;
         cnt   <= cnt_n;
         win_r <= win_n;
         if (st == LS_IDLE && start) begin
            org_r <= {1'b0, row};
            org_c <= {1'b0, col};
            ply   <= player;
         end
      end
   end

   always_comb begin
      st_n    = st;
      pos_r_n = pos_r;
      pos_c_n = pos_c;
      d_n     = d;
      neg_n   = neg;
      cnt_n   = cnt;
      win_n   = win_r;
      case (st)
         LS_IDLE: begin
            if (start) begin
               st_n    = LS_STEP;
               pos_r_n = {1'b0, row};
               pos_c_n = {1'b0, col};
               d_n     = 2'd0;
               neg_n   = 1'b0;
               cnt_n   = 4'd1;
               win_n   = 1'b0;
            end
         end
         LS_STEP: begin
            if (q_cell == ply) begin
               cnt_n   = cnt + 4'd1;
               pos_r_n = q_row;
               pos_c_n = q_col;
               if (cnt + 4'd1 == WL) begin
                  win_n = 1'b1;
                  st_n  = LS_DONE;
               end
            end else if (!neg) begin
               neg_n   = 1'b1;
               pos_r_n = org_r;
               pos_c_n = org_c;
            end else if (d == 2'd3) begin
               st_n = LS_DONE;
            end else begin
               d_n     = d + 2'd1;
               neg_n   = 1'b0;
               cnt_n   = 4'd1;
               pos_r_n = org_r;
               pos_c_n = org_c;
            end
         end
         LS_DONE: st_n = LS_IDLE;
         default: st_n = LS_IDLE;
      endcase
      if (clear) st_n = LS_IDLE;
   end

endmodule

// File: rtl/nxn_game_core.sv
// nxn_game_core: N x N, WIN_LEN-in-a-row two-player game controller.
//   clk, reset          : clock, async active-low reset
//   new_game            : synchronous restart
//   button_x, button_o  : single-cycle player presses
//   sel_row, sel_col    : requested move cell
//   rd_row, rd_col      : display read address -> rd_cell
//   turn_x, turn_o      : whose move it is (also high in that player's error state)
//   busy                : win scan in progress, presses dropped
//   game_st             : ASCII status 'X' 'O' 'C' 'E' 'n'
//   move_count          : tiles placed
//   win_row/col/dir     : winning move cell and run direction
//
// state     | meaning
// ST_START  | post-reset/new game, one cycle
// ST_TURN_X | waiting for X
// ST_ERR_X  | X made a bad press, still waiting for X
// ST_SCAN   | checking lines through the last move
// ST_TURN_O | waiting for O
// ST_ERR_O  | O made a bad press, still waiting for O
// ST_WIN_X  | X won (terminal)
// ST_WIN_O  | O won (terminal)
// ST_DRAW   | board full, no winner (terminal)
module nxn_game_core
   import game_pkg::*;
#(
   parameter int N       = 3,
   parameter int WIN_LEN = 3,
   parameter int IW      = $clog2(N),
   parameter int CW      = $clog2(N*N+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          new_game,
   input  logic          button_x,
   input  logic          button_o,
   input  logic [IW-1:0] sel_row,
   input  logic [IW-1:0] sel_col,
   input  logic [IW-1:0] rd_row,
   input  logic [IW-1:0] rd_col,
   output logic [1:0]    rd_cell,
   output logic          turn_x,
   output logic          turn_o,
   output logic          busy,
   output logic [7:0]    game_st,
   output logic [CW-1:0] move_count,
   output logic [IW-1:0] win_row,
   output logic [IW-1:0] win_col,
   output logic [1:0]    win_dir
);

   localparam logic [IW:0]   NB   = (IW+1)'(N);
   localparam logic [CW-1:0] FULL = CW'(N*N);

   game_state_t   state, state_n;
   logic [1:0]    board [N][N];
   logic [IW-1:0] last_row, last_col;
   logic          last_x, scan_go;
   logic [IW:0]   q_row, q_col;
   logic [1:0]    q_cell, sel_cell, wr_val;
   logic          scan_done, scan_win;
   logic [1:0]    scan_dir;
   logic          press, sel_ok, valid, wr_en, win_latch;

   assign sel_ok   = ({1'b0, sel_row} < NB) && ({1'b0, sel_col} < NB);
   assign sel_cell = sel_ok ? board[sel_row][sel_col] : CELL_EMPTY;
   assign press    = button_x | button_o;
   assign valid    = sel_ok && (sel_cell == CELL_EMPTY) && (button_x ^ button_o);

   assign q_cell  = ((q_row < NB) && (q_col < NB)) ?
                    board[q_row[IW-1:0]][q_col[IW-1:0]] : CELL_EMPTY;
   assign rd_cell = (({1'b0, rd_row} < NB) && ({1'b0, rd_col} < NB)) ?
                    board[rd_row][rd_col] : CELL_EMPTY;

   line_scan #(.N(N), .WIN_LEN(WIN_LEN), .IW(IW)) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clear  (new_game),
      .start  (scan_go),
      .row    (last_row),
      .col    (last_col),
      .player (last_x ? CELL_X : CELL_O),
      .q_row  (q_row),
      .q_col  (q_col),
      .q_cell (q_cell),
      .done   (scan_done),
      .win    (scan_win),
      .dir    (scan_dir)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_START;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      wr_en     = 1'b0;
      wr_val    = CELL_EMPTY;
      win_latch = 1'b0;
      case (state)
         ST_START: state_n = ST_TURN_X;
         ST_TURN_X, ST_ERR_X: begin
            if (press) begin
               if (button_x && valid) begin
                  wr_en   = 1'b1;
                  wr_val  = CELL_X;
                  state_n = ST_SCAN;
               end else if (!(button_o && valid)) begin
                  state_n = ST_ERR_X;
               end
            end
         end
         ST_TURN_O, ST_ERR_O: begin
            if (press) begin
               if (button_o && valid) begin
                  wr_en   = 1'b1;
                  wr_val  = CELL_O;
                  state_n = ST_SCAN;
               end else if (!(button_x && valid)) begin
                  state_n = ST_ERR_O;
               end
            end
         end
         ST_SCAN: begin
            if (scan_done) begin
               if (scan_win) begin
                  win_latch = 1'b1;
                  state_n   = last_x ? ST_WIN_X : ST_WIN_O;
               end else if (move_count == FULL) begin
                  state_n = ST_DRAW;
               end else begin
                  state_n = last_x ? ST_TURN_O : ST_TURN_X;
               end
            end
         end
         default: ;
      endcase
      if (new_game) begin
         state_n   = ST_START;
         wr_en     = 1'b0;
         win_latch = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               board[r][c] <= CELL_EMPTY;
         move_count <= '0;
         last_row   <= '0;
         last_col   <= '0;
         last_x     <= 1'b0;
         scan_go    <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         win_dir    <= '0;
      end else if (new_game) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               board[r][c] <= CELL_EMPTY;
         move_count <= '0;
         last_row   <= '0;
         last_col   <= '0;
         last_x     <= 1'b0;
         scan_go    <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         win_dir    <= '0;
      end else begin
         scan_go <= wr_en;
         if (wr_en) begin
            board[sel_row][sel_col] <= wr_val;
            move_count <= move_count + 1'b1;
            last_row   <= sel_row;
            last_col   <= sel_col;
            last_x     <= (wr_val == CELL_X);
         end
         if (win_latch) begin
            win_row <= last_row;
            win_col <= last_col;
            win_dir <= scan_dir;
         end
      end
   end

   assign turn_x = (state == ST_TURN_X) || (state == ST_ERR_X);
   assign turn_o = (state == ST_TURN_O) || (state == ST_ERR_O);
   assign busy   = (state == ST_SCAN);

   always_comb begin
      game_st = ASC_N;
      case (state)
         ST_WIN_X:           game_st = ASC_X;
         ST_WIN_O:           game_st = ASC_O;
         ST_DRAW:            game_st = ASC_C;
         ST_ERR_X, ST_ERR_O: game_st = ASC_E;
         default:            game_st = ASC_N;
      endcase
   end

endmodule

// File: doc/nxn_game_core.md
Name: nxn_game_core

Overview:
- Parametrised successor of the 3x3 tic-tac-toe game controller: N x N board, WIN_LEN-in-a-row victory, binary row/column move addressing.
- Win detection is a sequential scanner that walks only the lines through the last placed cell. It replaces the fixed 8-trey combinational checker.
- Sits between the debounced player buttons and the board display / status drivers. Status encoding is unchanged, so the existing ASCII status path carries over.

Parameters:
- N, 3, board side length; legal range 3..8.
- WIN_LEN, 3, run length needed to win; legal range 3..N.
- IW, $clog2(N), width of row/column indices; derived, do not override.
- CW, $clog2(N*N+1), width of the move counter; derived.

Ports:
- clk, input, 1, system clock; all state changes on posedge.
- reset, input, 1, asynchronous active-low reset (asserted when 0).
- new_game, input, 1, synchronous restart pulse; same effect as reset, one cycle later.
- button_x, input, 1, single-cycle debounced press from player X.
- button_o, input, 1, single-cycle debounced press from player O.
- sel_row, input, IW, row index of the requested move.
- sel_col, input, IW, column index of the requested move.
- rd_row, input, IW, display read row.
- rd_col, input, IW, display read column.
- rd_cell, output, 2, combinational board read: 00 empty, 01 X, 10 O; 00 when rd index is out of range.
- turn_x, output, 1, high in TURN_X and ERR_X.
- turn_o, output, 1, high in TURN_O and ERR_O.
- busy, output, 1, high in SCAN (moves ignored).
- game_st, output, 8, ASCII status: 'X' win X, 'O' win O, 'C' draw, 'E' error, 'n' otherwise.
- move_count, output, CW, number of placed tiles.
- win_row, output, IW, row of the winning move's cell; 0 until a win.
- win_col, output, IW, column of the winning move's cell; 0 until a win.
- win_dir, output, 2, direction of the winning run: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.

Behaviour:
- Reset (reset=0):
  - board all 00, move_count 0, state START, win_* 0, busy 0, game_st 'n', turn_x 0, turn_o 0.
- States and transitions:
  - START -> TURN_X unconditionally, next cycle.
- Valid move: sel_row<N, sel_col<N, target cell empty, and exactly one of button_x/button_o is high.
- Press: either button high this cycle.
- TURN_X / ERR_X:
  - button_x alone with a valid move: write 01 to the cell next edge, move_count+1, latch the cell as last move, go to SCAN.
  - Any press that is not a valid move: go to ERR_X with the board unchanged. This covers occupied cell, out-of-range index, or both buttons pressed together.
  - button_o alone with a valid move while waiting for X: ignored, no state change.
- TURN_O / ERR_O: mirror image of TURN_X / ERR_X with the buttons and cell value 10.
- SCAN, per direction d = 0..3 in order:
  - count starts at 1 (the placed cell).
  - Step +delta one cell per cycle; stop on board edge, non-matching cell, or count==WIN_LEN.
  - Then step -delta the same way.
  - count>=WIN_LEN: latch win_row/win_col/win_dir and go to WIN_X or WIN_O.
- SCAN exit when no direction wins:
  - move_count==N*N -> DRAW.
  - Otherwise -> TURN_O after an X move, TURN_X after an O move.
- SCAN latency: 1 cycle setup, plus at most 8*(WIN_LEN-1) step cycles, plus 1 cycle decide. Each edge or mismatch stop costs one cycle. Presses during SCAN are dropped.
- WIN_X, WIN_O and DRAW are terminal. Only new_game or reset leaves them.
- new_game: highest synchronous priority, in any state including mid-SCAN.
  - Next edge: board cleared, counters and win_* cleared, state START.
- Asynchronous reset mid-SCAN abandons the scan immediately.
- A win on the final cell reports WIN, not DRAW.
- Indices are unsigned. Neighbour coordinate arithmetic uses IW+1 bits so that -1 and N are detected as off-board.

Decomposition:
- Package game_pkg:
  - state encoding: START, TURN_X, ERR_X, SCAN, TURN_O, ERR_O, WIN_X, WIN_O, DRAW.
  - cell encoding: EMPTY, X, O.
  - ASCII constants: X/O/C/E/n.
  - direction delta table, (0,1) (1,0) (1,1) (1,-1).
- Sub-module line_scan: the stepping counter and direction sequencer.
  - start/row/col/player in; done/win/dir out.
  - Reads the board through a cell-query port.

Test Plan:
- N=3, WIN_LEN=3, X plays (0,0),(1,1),(2,2) interleaved with O at (0,1),(0,2) -> game_st 'X', win_dir 2, move_count 5, busy pulses are each at most 18 cycles.
- N=3, X presses at (1,1), then O presses at (1,1) -> ERR_O, game_st 'E', turn_o 1. O then moves to (2,0) -> SCAN, then TURN_X.
- N=5, WIN_LEN=4, O completes row 3 cols 1..4, last tile at (3,2) -> WIN_O, win_row 3, win_col 2, win_dir 0; a 3-long run does not win.
- N=3, fill the board with no line (X,O,X / X,O,O / O,X,X) -> DRAW, game_st 'C', move_count 9. Further presses are ignored.
- Both buttons in the same cycle, and sel_row=3 with N=3 -> ERR_X, board unchanged, move_count unchanged.
- Assert new_game mid-SCAN, and separately drive reset=0 mid-SCAN -> all cells read 00, move_count 0, START then TURN_X, game_st 'n'.
